dof_pipe_stage: RTL

//  Parametrised, registered decode/operand-fetch stage: decodes IR, reads register-file operands, resolves
//  RAW hazards by EX/WB forwarding plus load-use stall, and holds the result in a DOF->EX pipeline register.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/Instruction_decoder.sv | 62 ++++++
 rtl/operand_bypass.sv | 39 +++
 rtl/dof_pipe_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA definitions: IR field positions, opcodes, control encodings and the decoded-control bundle.
// Purely declarative; no timing or backpressure of its own.
package cpu_pkg;

    localparam int IR_W   = 32;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 25;
    localparam int DA_MSB = 24;
    localparam int DA_LSB = 20;
    localparam int AA_MSB = 19;
    localparam int AA_LSB = 15;
    localparam int BA_MSB = 14;
    localparam int BA_LSB = 10;
    localparam int SH_MSB = 4;
    localparam int SH_LSB = 0;

    localparam logic [1:0] MD_FU   = 2'b00;
    localparam logic [1:0] MD_LOAD = 2'b01;
    localparam logic [1:0] MD_SLT  = 2'b10;

    localparam logic [1:0] BS_NEXT = 2'b00;
    localparam logic [1:0] BS_BRZ  = 2'b01;
    localparam logic [1:0] BS_JREG = 2'b10;
    localparam logic [1:0] BS_JMP  = 2'b11;

    localparam logic [4:0] FS_PASS = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b00010;
    localparam logic [4:0] FS_SUB  = 5'b00101;
    localparam logic [4:0] FS_LINK = 5'b00111;
    localparam logic [4:0] FS_AND  = 5'b01000;
    localparam logic [4:0] FS_SHL  = 5'b11000;

    typedef enum logic [6:0] {
        OP_NOP = 7'h00,
        OP_ST  = 7'h01,
        OP_ADD = 7'h02,
        OP_SUB = 7'h05,
        OP_JML = 7'h07,
        OP_AND = 7'h08,
        OP_BZ  = 7'h20,
        OP_LD  = 7'h21,
        OP_ADI = 7'h22,
        OP_ANI = 7'h28,
        OP_LSL = 7'h30,
        OP_BNZ = 7'h60,
        OP_JMR = 7'h61,
        OP_SLT = 7'h65
    } opcode_e;

    typedef struct packed {
        logic       rw;
        logic [1:0] md;
        logic [1:0] bs;
        logic       ps;
        logic       mw;
        logic [4:0] fs;
        logic       ma;
        logic       mb;
        logic       cs;
    } dec_t;

endpackage

// File: rtl/Instruction_decoder.sv
// Combinational instruction decoder: IR -> register addresses and datapath controls.
// Zero latency, no handshake; unknown opcodes decode as a NOP.
module Instruction_decoder
    import cpu_pkg::*;
(
    input  logic [IR_W-1:0] IR,
    output logic [4:0]      DA,
    output logic [4:0]      AA,
    output logic [4:0]      BA,
    output logic            RW,
    output logic [1:0]      MD,
    output logic [1:0]      BS,
    output logic            PS,
    output logic            MW,
    output logic [4:0]      FS,
    output logic            MA,
    output logic            MB,
    output logic            CS
);

    dec_t dec;
    logic unused_ir;

    assign unused_ir = ^IR[BA_LSB-1:0];

    always_comb begin
        dec = '0;
        case (opcode_e'(IR[OP_MSB:OP_LSB]))
            OP_ADD: begin dec.rw = 1'b1; dec.fs = FS_ADD; end
            OP_SUB: begin dec.rw = 1'b1; dec.fs = FS_SUB; end
            OP_AND: begin dec.rw = 1'b1; dec.fs = FS_AND; end
            OP_LSL: begin dec.rw = 1'b1; dec.fs = FS_SHL; end
            OP_SLT: begin dec.rw = 1'b1; dec.fs = FS_SUB; dec.md = MD_SLT; end
            OP_ST:  begin dec.mw = 1'b1; dec.fs = FS_PASS; end
            OP_LD:  begin dec.rw = 1'b1; dec.md = MD_LOAD; end
            OP_ADI: begin dec.rw = 1'b1; dec.fs = FS_ADD; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_ANI: begin dec.rw = 1'b1; dec.fs = FS_AND; dec.mb = 1'b1; end
            OP_BZ:  begin dec.bs = BS_BRZ; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_BNZ: begin dec.bs = BS_BRZ; dec.ps = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_JMR: begin dec.bs = BS_JREG; end
            OP_JML: begin
                dec.rw = 1'b1; dec.bs = BS_JMP; dec.fs = FS_LINK;
                dec.ma = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    assign DA = IR[DA_MSB:DA_LSB];
    assign AA = IR[AA_MSB:AA_LSB];
    assign BA = IR[BA_MSB:BA_LSB];
    assign RW = dec.rw;
    assign MD = dec.md;
    assign BS = dec.bs;
    assign PS = dec.ps;
    assign MW = dec.mw;
    assign FS = dec.fs;
    assign MA = dec.ma;
    assign MB = dec.mb;
    assign CS = dec.cs;

endmodule

// File: rtl/operand_bypass.sv
// Per-source operand forwarding mux (R0, EX, WB, register file) plus EX/WB match flags for hazard logic.
// Zero latency; no handshake of its own.
module operand_bypass #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]  src,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_rw,
    input  logic [RAW-1:0]  ex_da,
    input  logic            ex_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_rw,
    input  logic [RAW-1:0]  wb_da,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            ex_hit,
    output logic            wb_hit
);

    logic src_nz;

    always_comb begin
        src_nz = (src != '0);
        ex_hit = src_nz && ex_rw && (ex_da == src);
        wb_hit = src_nz && wb_rw && (wb_da == src);
        // A load in EX has no result yet, so it falls through to older producers.
        if (!src_nz) begin
            data = '0;
        end else if (ex_hit && !ex_load) begin
            data = ex_result;
        end else if (wb_hit) begin
            data = wb_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/dof_pipe_stage.sv
// Registered decode/operand-fetch stage with forwarding, load-use stall and flush; 1-cycle latency.
// Backpressure: holds its register while out_ready is low; in_ready drops on hold, hazard, flush or reset.
module dof_pipe_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RAW    = 5,
    parameter int IMW    = 15,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     IR,
    input  logic [XLEN-1:0] PC_1,
    output logic [RAW-1:0]  AA,
    output logic [RAW-1:0]  BA,
    input  logic [XLEN-1:0] A_DATA,
    input  logic [XLEN-1:0] B_DATA,
    input  logic            ex_rw,
    input  logic [RAW-1:0]  ex_da,
    input  logic            ex_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_rw,
    input  logic [RAW-1:0]  wb_da,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Bus_A,
    output logic [XLEN-1:0] Bus_B,
    output logic            RW,
    output logic            PS,
    output logic            MW,
    output logic [RAW-1:0]  DA,
    output logic [4:0]      FS,
    output logic [4:0]      SH,
    output logic [1:0]      MD,
    output logic [1:0]      BS
);

    localparam bit FWD_ON = (FWD_EN != 0);

    logic [4:0]      dec_da, dec_aa, dec_ba, dec_fs;
    logic [1:0]      dec_md, dec_bs;
    logic            dec_rw, dec_ps, dec_mw, dec_ma, dec_mb, dec_cs;

    logic [XLEN-1:0] fwd_a, fwd_b, const_ext, opnd_a, opnd_b;
    logic            ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
    logic            stall_a, stall_b, hazard, advance;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] bus_a_q, bus_a_d, bus_b_q, bus_b_d;
    logic            rw_q, rw_d, ps_q, ps_d, mw_q, mw_d;
    logic [RAW-1:0]  da_q, da_d;
    logic [4:0]      fs_q, fs_d, sh_q, sh_d;
    logic [1:0]      md_q, md_d, bs_q, bs_d;

    Instruction_decoder u_dec (
        .IR (IR),
        .DA (dec_da),
        .AA (dec_aa),
        .BA (dec_ba),
        .RW (dec_rw),
        .MD (dec_md),
        .BS (dec_bs),
        .PS (dec_ps),
        .MW (dec_mw),
        .FS (dec_fs),
        .MA (dec_ma),
        .MB (dec_mb),
        .CS (dec_cs)
    );

    assign AA = RAW'(dec_aa);
    assign BA = RAW'(dec_ba);

    operand_bypass #(.XLEN(XLEN), .RAW(RAW)) u_byp_a (
        .src       (AA),
        .rf_data   (A_DATA),
        .ex_rw     (ex_rw),
        .ex_da     (ex_da),
        .ex_load   (ex_load),
        .ex_result (ex_result),
        .wb_rw     (wb_rw),
        .wb_da     (wb_da),
        .wb_data   (wb_data),
        .data      (fwd_a),
        .ex_hit    (ex_hit_a),
        .wb_hit    (wb_hit_a)
    );

    operand_bypass #(.XLEN(XLEN), .RAW(RAW)) u_byp_b (
        .src       (BA),
        .rf_data   (B_DATA),
        .ex_rw     (ex_rw),
        .ex_da     (ex_da),
        .ex_load   (ex_load),
        .ex_result (ex_result),
        .wb_rw     (wb_rw),
        .wb_da     (wb_da),
        .wb_data   (wb_data),
        .data      (fwd_b),
        .ex_hit    (ex_hit_b),
        .wb_hit    (wb_hit_b)
    );

    always_comb begin
        const_ext = dec_cs ? {{(XLEN-IMW){IR[IMW-1]}}, IR[IMW-1:0]}
                           : {{(XLEN-IMW){1'b0}}, IR[IMW-1:0]};
        opnd_a    = dec_ma ? PC_1 : fwd_a;
        opnd_b    = dec_mb ? const_ext : fwd_b;
    end

    // Without forwarding any producer match stalls; with it only a load in EX does.
    always_comb begin
        stall_a  = !dec_ma && ((ex_hit_a && (ex_load || !FWD_ON)) || (wb_hit_a && !FWD_ON));
        stall_b  = !dec_mb && ((ex_hit_b && (ex_load || !FWD_ON)) || (wb_hit_b && !FWD_ON));
        hazard   = in_valid && (stall_a || stall_b);
        advance  = !valid_q || out_ready;
        in_ready = advance && !hazard && !flush && !reset;
    end

    always_comb begin
        valid_d = valid_q;
        bus_a_d = bus_a_q;
        bus_b_d = bus_b_q;
        rw_d    = rw_q;
        ps_d    = ps_q;
        mw_d    = mw_q;
        da_d    = da_q;
        fs_d    = fs_q;
        sh_d    = sh_q;
        md_d    = md_q;
        bs_d    = bs_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            if (hazard || !in_valid) begin
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b1;
                bus_a_d = opnd_a;
                bus_b_d = opnd_b;
                rw_d    = dec_rw;
                ps_d    = dec_ps;
                mw_d    = dec_mw;
                da_d    = RAW'(dec_da);
                fs_d    = dec_fs;
                sh_d    = IR[SH_MSB:SH_LSB];
                md_d    = dec_md;
                bs_d    = dec_bs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            bus_a_q <= '0;
            bus_b_q <= '0;
            rw_q    <= 1'b0;
            ps_q    <= 1'b0;
            mw_q    <= 1'b0;
            da_q    <= '0;
            fs_q    <= '0;
            sh_q    <= '0;
            md_q    <= '0;
            bs_q    <= '0;
        end else begin
            valid_q <= valid_d;
            bus_a_q <= bus_a_d;
            bus_b_q <= bus_b_d;
            rw_q    <= rw_d;
            ps_q    <= ps_d;
            mw_q    <= mw_d;
            da_q    <= da_d;
            fs_q    <= fs_d;
            sh_q    <= sh_d;
            md_q    <= md_d;
            bs_q    <= bs_d;
        end
    end

    assign out_valid = valid_q;
    assign Bus_A     = bus_a_q;
    assign Bus_B     = bus_b_q;
    assign RW        = rw_q;
    assign PS        = ps_q;
    assign MW        = mw_q;
    assign DA        = da_q;
    assign FS        = fs_q;
    assign SH        = sh_q;
    assign MD        = md_q;
    assign BS        = bs_q;

endmodule
